// File: rtl/mul_share_if.sv
// Operand-request and result handshake bundle for the shared multiplier.
// valid/ready: a transfer happens on a rising edge where both are high; the producer holds its payload stable while valid is high and ready is low.
interface mul_share_if #(
    parameter int N = 8
);
    logic           req0_valid;
    logic [N-1:0]   req0_a;
    logic [N-1:0]   req0_b;
    logic           req0_ready;
    logic           req1_valid;
    logic [N-1:0]   req1_a;
    logic [N-1:0]   req1_b;
    logic           req1_ready;
    logic           res_valid;
    logic [2*N-1:0] res_q;
    logic           res_id;
    logic           res_ready;

    modport master (
        output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, res_ready,
        input  req0_ready, req1_ready, res_valid, res_q, res_id
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, res_ready,
        output req0_ready, req1_ready, res_valid, res_q, res_id
    );
endinterface

// File: rtl/mul_share_arbiter.sv
// Two-requester round-robin front end around one shift-add multiplier
// that retires one partial product per cycle.
module mul_share_arbiter #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         stop,
    mul_share_if.slave   bus,
    output logic         busy,
    output logic [1:0]   dbg_state
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int W  = 2 * N;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [N-1:0]  a_reg;
    logic [N-1:0]  b_reg;
    logic [W-1:0]  acc;
    logic [W-1:0]  pp;
    logic [W-1:0]  acc_sum;
    logic [CW-1:0] cnt;
    logic          last_bit;
    logic          last_grant;
    logic          grant_any;
    logic          grant_id;

    // Grant: a lone requester wins; on a tie the one not served last time wins.
    always_comb begin
        grant_any = 1'b0;
        grant_id  = 1'b0;
        if (state == IDLE && !stop) begin
            if (bus.req0_valid && bus.req1_valid) begin
                grant_any = 1'b1;
                grant_id  = ~last_grant;
            end else if (bus.req0_valid) begin
                grant_any = 1'b1;
                grant_id  = 1'b0;
            end else if (bus.req1_valid) begin
                grant_any = 1'b1;
                grant_id  = 1'b1;
            end
        end
    end

    assign bus.req0_ready = grant_any && !grant_id;
    assign bus.req1_ready = grant_any && grant_id;

    assign pp       = b_reg[cnt] ? ({{N{1'b0}}, a_reg} << cnt) : '0;
    assign acc_sum  = acc + pp;
    assign last_bit = (cnt == LAST);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (grant_any) state_nx = CALC;
            CALC: begin
                if (stop)          state_nx = IDLE;
                else if (last_bit) state_nx = DONE;
            end
            DONE: begin
                if (stop || bus.res_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg         <= '0;
            b_reg         <= '0;
            acc           <= '0;
            cnt           <= '0;
            bus.res_valid <= 1'b0;
            bus.res_q     <= '0;
            bus.res_id    <= 1'b0;
            last_grant    <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        a_reg      <= grant_id ? bus.req1_a : bus.req0_a;
                        b_reg      <= grant_id ? bus.req1_b : bus.req0_b;
                        acc        <= '0;
                        cnt        <= '0;
                        bus.res_id <= grant_id;
                        last_grant <= grant_id;
                    end
                end
                CALC: begin
                    if (stop) begin
                        acc <= '0;
                        cnt <= '0;
                    end else begin
                        acc <= acc_sum;
                        cnt <= cnt + CW'(1);
                        if (last_bit) begin
                            bus.res_q     <= acc_sum;
                            bus.res_valid <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    // stop outranks the consumer: the result is dropped.
                    if (stop) begin
                        bus.res_valid <= 1'b0;
                        acc           <= '0;
                    end else if (bus.res_ready) begin
                        bus.res_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy      = (state != IDLE);
    assign dbg_state = state;
endmodule

// File: tb/tb_mul_share_arbiter.sv
// Randomized and directed bench for mul_share_arbiter with a queue-based
// scoreboard fed by an abstract arbitration/latency model.
module tb_mul_share_arbiter;
  localparam int N  = 8;
  localparam int W  = 2 * N;
  localparam int EW = W + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic stop = 1'b0;
  logic busy;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  mul_share_if #(.N(N)) bus ();

  mul_share_arbiter #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .stop      (stop),
    .bus       (bus),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  logic [EW-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int n_res = 0;

  // model: 0 idle, 1 multiplying (m_left cycles to go), 2 holding a result
  int   m_phase = 0;
  int   m_left  = 0;
  logic m_last  = 1'b1;
  logic prev_rst = 1'b1;
  logic acc0 = 1'b0;
  logic acc1 = 1'b0;
  logic e_r0, e_r1;
  logic [EW-1:0] front;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] prod(input logic [N-1:0] a, input logic [N-1:0] b);
    longint p;
    p = longint'(a) * longint'(b);
    return W'(p);
  endfunction

  // Monitor + reference model: check what the DUT shows, then predict the next edge.
  always @(negedge clk) begin
    acc0 = 1'b0;
    acc1 = 1'b0;
    if (rst) begin
      m_phase = 0;
      m_left = 0;
      m_last = 1'b1;
      exp_q.delete();
      prev_rst = 1'b1;
    end else begin
      if (prev_rst) begin
        check("reset_res_q", longint'(bus.res_q), 0);
        check("reset_res_id", longint'(bus.res_id), 0);
      end
      prev_rst = 1'b0;

      e_r0 = 1'b0;
      e_r1 = 1'b0;
      if (m_phase == 0 && !stop) begin
        if (bus.req0_valid && bus.req1_valid) begin
          if (m_last) e_r1 = 1'b1; else e_r0 = 1'b1;
          // ties go to the requester not served last time
          e_r0 = !m_last ? 1'b0 : 1'b0;
          e_r0 = (m_last == 1'b1);
          e_r1 = (m_last == 1'b0);
        end else if (bus.req0_valid) begin
          e_r0 = 1'b1;
        end else if (bus.req1_valid) begin
          e_r1 = 1'b1;
        end
      end
      check("req0_ready", longint'(bus.req0_ready), longint'(e_r0));
      check("req1_ready", longint'(bus.req1_ready), longint'(e_r1));
      check("busy", longint'(busy), longint'(m_phase != 0));
      check("res_valid", longint'(bus.res_valid), longint'(m_phase == 2));

      if (bus.res_valid) begin
        if (exp_q.size() == 0) begin
          check("res_unexpected", 1, 0);
        end else begin
          front = exp_q[0];
          check("res_q", longint'(bus.res_q), longint'(front[W-1:0]));
          check("res_id", longint'(bus.res_id), longint'(front[W]));
        end
      end

      acc0 = bus.req0_valid && bus.req0_ready;
      acc1 = bus.req1_valid && bus.req1_ready;

      case (m_phase)
        0: begin
          if (e_r0) begin
            exp_q.push_back({1'b0, prod(bus.req0_a, bus.req0_b)});
            m_last = 1'b0;
            m_phase = 1;
            m_left = N;
          end else if (e_r1) begin
            exp_q.push_back({1'b1, prod(bus.req1_a, bus.req1_b)});
            m_last = 1'b1;
            m_phase = 1;
            m_left = N;
          end
        end
        1: begin
          if (stop) begin
            m_phase = 0;
            if (exp_q.size() > 0) void'(exp_q.pop_back());
          end else begin
            m_left--;
            if (m_left == 0) m_phase = 2;
          end
        end
        default: begin
          if (stop) begin
            m_phase = 0;
            if (exp_q.size() > 0) void'(exp_q.pop_front());
          end else if (bus.res_ready) begin
            m_phase = 0;
            n_res++;
            if (exp_q.size() > 0) void'(exp_q.pop_front());
          end
        end
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N-1:0] rand_op();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return '1;
      2: return N'(1);
      default: return N'($urandom);
    endcase
  endfunction

  task automatic send(input int id, input logic [N-1:0] a, input logic [N-1:0] b);
    logic got;
    got = 1'b0;
    if (id == 0) begin
      bus.req0_valid = 1'b1; bus.req0_a = a; bus.req0_b = b;
    end else begin
      bus.req1_valid = 1'b1; bus.req1_a = a; bus.req1_b = b;
    end
    for (int i = 0; i < 100 && !got; i++) begin
      tick();
      got = (id == 0) ? acc0 : acc1;
    end
    check("send_accepted", longint'(got), 1);
    // operands are scrambled after the accept edge; the running multiply must not see them
    if (id == 0) begin
      bus.req0_valid = 1'b0; bus.req0_a = N'($urandom); bus.req0_b = N'($urandom);
    end else begin
      bus.req1_valid = 1'b0; bus.req1_a = N'($urandom); bus.req1_b = N'($urandom);
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      if (!busy && !bus.res_valid) break;
      tick();
    end
    check("wait_idle", longint'(busy), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
  endtask

  int base;

  initial begin
    bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0;
    bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0;
    bus.res_ready = 1'b1;
    do_reset();

    // basic 3*5 from requester 0
    send(0, N'(3), N'(5));
    wait_idle();

    // both valid from reset: strict alternation 0,1,0,1
    rst = 1'b1;
    bus.req0_valid = 1'b1; bus.req0_a = N'(7);  bus.req0_b = N'(9);
    bus.req1_valid = 1'b1; bus.req1_a = N'(12); bus.req1_b = N'(11);
    repeat (2) tick();
    rst = 1'b0;
    base = n_res;
    for (int i = 0; i < 200 && n_res < base + 4; i++) tick();
    check("alternation_count", longint'(n_res - base >= 4), 1);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    wait_idle();

    // operand extremes
    send(1, N'(255), N'(255)); wait_idle();
    send(0, N'(0), N'(200));   wait_idle();
    send(1, N'(200), N'(0));   wait_idle();
    send(0, N'(1), N'(1));     wait_idle();

    // result backpressure with a competing request waiting
    bus.res_ready = 1'b0;
    send(0, N'(13), N'(17));
    for (int i = 0; i < 20 && !bus.res_valid; i++) tick();
    check("bp_res_valid", longint'(bus.res_valid), 1);
    bus.req1_valid = 1'b1; bus.req1_a = N'(2); bus.req1_b = N'(3);
    repeat (5) tick();
    bus.res_ready = 1'b1;
    send(1, N'(2), N'(3));
    wait_idle();

    // abort mid-multiply; last_grant stays at 0 so a lone req1 still goes
    base = n_res;
    send(0, N'(10), N'(10));
    repeat (3) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    wait_idle();
    check("abort_no_result", longint'(n_res), longint'(base));
    send(1, N'(4), N'(4));
    wait_idle();

    // reset in the middle of a multiply with requester 1 pending
    send(1, N'(50), N'(60));
    repeat (2) tick();
    bus.req1_valid = 1'b1; bus.req1_a = N'(5); bus.req1_b = N'(6);
    rst = 1'b1;
    repeat (2) tick();
    bus.req0_valid = 1'b1; bus.req0_a = N'(8); bus.req0_b = N'(9);
    rst = 1'b0;
    for (int i = 0; i < 10 && !(acc0 || acc1); i++) tick();
    check("rst_first_grant_req0", longint'(acc0), 1);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    wait_idle();

    // randomized traffic, backpressure and occasional aborts
    for (int c = 0; c < 3000; c++) begin
      tick();
      if (!bus.req0_valid || acc0) begin
        bus.req0_valid = ($urandom_range(0, 2) != 0);
        bus.req0_a = rand_op(); bus.req0_b = rand_op();
      end
      if (!bus.req1_valid || acc1) begin
        bus.req1_valid = ($urandom_range(0, 2) != 0);
        bus.req1_a = rand_op(); bus.req1_b = rand_op();
      end
      bus.res_ready = ($urandom_range(0, 3) != 0);
      stop = ($urandom_range(0, 60) == 0);
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.res_ready = 1'b1;
    stop = 1'b0;
    wait_idle();
    check("results_seen", longint'(n_res > 50), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
